// File: rtl/uart_tx_buffered_pkg.sv
// rtl/uart_tx_buffered_pkg.sv - shared types and field positions for the buffered UART transmitter
//
// Purpose: serializer FSM states, parity-mode codes, and bit positions of
//          the write word (din) and status word (q).
// Ports:   none (package).

package uart_tx_buffered_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   // Parity-mode codes; 2'b00 and 2'b11 both mean no parity cell.
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Write-word fields
   localparam int DIN_PUSH    = 8;
   localparam int DIN_CLEAR   = 9;
   localparam int DIN_PAR_LSB = 10;
   localparam int DIN_CFG_WR  = 12;

   // Status-word fields
   localparam int Q_EMPTY     = 0;
   localparam int Q_FULL      = 1;
   localparam int Q_BUSY      = 2;
   localparam int Q_DONE      = 3;
   localparam int Q_OVF       = 4;
   localparam int Q_PAR       = 5;
   localparam int Q_COUNT_LSB = 8;

   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO feeding the UART serializer
//
// Purpose: DEPTH-entry FIFO (DEPTH a power of 2), pointers wrap modulo DEPTH.
//          A push while full is accepted only if a pop happens on the same edge.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset
//   push_i   in   enqueue data_i
//   pop_i    in   dequeue head (ignored when empty)
//   data_i   in   WIDTH write data
//   data_o   out  WIDTH head entry
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
//   count_o  out  occupancy, $clog2(DEPTH)+1 bits

module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   assign do_pop  = pop_i & ~empty_o;
   // A pop on the same edge frees the slot a full FIFO needs for this push.
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter with status word
//
// Purpose: register decode of the write word, sticky flags, TX FIFO and
//          start/data/[parity]/stop serializer.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   we         in   write strobe for din
//   din        in   32-bit write word (byte, push, clear, cfg_wr, parity)
//   q          out  32-bit status (empty, full, busy, stickies, parity, count)
//   tx_serial  out  serial line, idle high, registered
//   tx_done    out  one-cycle pulse after the last stop cell

module uart_tx_buffered
   import uart_tx_buffered_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] q,
   output logic        tx_serial,
   output logic        tx_done
);

   localparam int TIMER_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W   = $clog2(DATA_BITS);
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

   logic                 push, clear, cfg_wr;
   logic                 fifo_pop, fifo_full, fifo_empty;
   logic [DATA_BITS-1:0] fifo_dout;
   logic [CNT_W-1:0]     fifo_count;
   logic                 timer_wrap, done_pulse;
   logic                 unused_din;

   logic [1:0]           cfg_q, cfg_d;
   logic                 done_sticky_q, done_sticky_d;
   logic                 ovf_q, ovf_d;
   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_en_q, par_en_d;
   logic                 par_bit_q, par_bit_d;
   logic                 tx_q, tx_d;
   logic                 tx_done_q;

   assign push   = we & din[DIN_PUSH];
   assign clear  = we & din[DIN_CLEAR];
   assign cfg_wr = we & din[DIN_CFG_WR];
   assign unused_din = ^din;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (push),
      .pop_i   (fifo_pop),
      .data_i  (din[DATA_BITS-1:0]),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Register side: config and sticky flags; a same-edge set beats clear.
   always_comb begin
      cfg_d         = cfg_wr ? din[DIN_PAR_LSB +: 2] : cfg_q;
      done_sticky_d = done_sticky_q;
      ovf_d         = ovf_q;
      if (clear) begin
         done_sticky_d = 1'b0;
         ovf_d         = 1'b0;
      end
      if (done_pulse) done_sticky_d = 1'b1;
      if (push & fifo_full & ~fifo_pop) ovf_d = 1'b1;
   end

   assign timer_wrap = (timer_q == TIMER_W'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      bit_d      = bit_q;
      stop_d     = stop_q;
      shift_d    = shift_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      tx_d       = tx_q;
      done_pulse = 1'b0;
      fifo_pop   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               // Parity mode and parity bit are frozen here so a config
               // write mid-frame only affects later frames.
               fifo_pop  = 1'b1;
               shift_d   = fifo_dout;
               par_en_d  = parity_enabled(cfg_q);
               par_bit_d = (cfg_q == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
               tx_d      = 1'b0;
               timer_d   = '0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            timer_d = timer_q + TIMER_W'(1);
            if (timer_wrap) begin
               timer_d = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            timer_d = timer_q + TIMER_W'(1);
            if (timer_wrap) begin
               timer_d = '0;
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  stop_d = 1'b0;
                  if (par_en_q) begin
                     tx_d    = par_bit_q;
                     state_d = ST_PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = ST_STOP;
                  end
               end else begin
                  // tx takes bit 1 now because bit 0 was the cell just sent.
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            timer_d = timer_q + TIMER_W'(1);
            if (timer_wrap) begin
               timer_d = '0;
               stop_d  = 1'b0;
               tx_d    = 1'b1;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            timer_d = timer_q + TIMER_W'(1);
            tx_d    = 1'b1;
            if (timer_wrap) begin
               timer_d = '0;
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  done_pulse = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_q         <= 2'b00;
         done_sticky_q <= 1'b0;
         ovf_q         <= 1'b0;
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         bit_q         <= '0;
         stop_q        <= 1'b0;
         shift_q       <= '0;
         par_en_q      <= 1'b0;
         par_bit_q     <= 1'b0;
         tx_q          <= 1'b1;
         tx_done_q     <= 1'b0;
      end else begin
         cfg_q         <= cfg_d;
         done_sticky_q <= done_sticky_d;
         ovf_q         <= ovf_d;
         state_q       <= state_d;
         timer_q       <= timer_d;
         bit_q         <= bit_d;
         stop_q        <= stop_d;
         shift_q       <= shift_d;
         par_en_q      <= par_en_d;
         par_bit_q     <= par_bit_d;
         tx_q          <= tx_d;
         tx_done_q     <= done_pulse;
      end
   end

   assign tx_serial = tx_q;
   assign tx_done   = tx_done_q;

   always_comb begin
      q                         = '0;
      q[Q_EMPTY]                = fifo_empty;
      q[Q_FULL]                 = fifo_full;
      q[Q_BUSY]                 = (state_q != ST_IDLE);
      q[Q_DONE]                 = done_sticky_q;
      q[Q_OVF]                  = ovf_q;
      q[Q_PAR]                  = parity_enabled(cfg_q);
      q[Q_COUNT_LSB +: CNT_W]   = fifo_count;
   end

endmodule
